mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width, legal range 32..64.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter CNT_W, default 32, retired-instruction counter width.
REQ-004 Reset: rst, asynchronous, active-high; clock: clk.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 imem_req  out  1  instruction fetch request.
REQ-008 imem_addr  out  XLEN  fetch address, equal to pc.
REQ-009 imem_ready  in  1  fetch completion; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  in  32  fetched instruction.
REQ-011 dmem_req  out  1  data access request.
REQ-012 dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
REQ-013 dmem_ready  in  1  data access completion.
REQ-014 rs_data  in  XLEN  register-file rs read value, used by jr.
REQ-015 alu_zero  in  1  ALU result-is-zero flag.
REQ-016 ir  out  32  latched instruction register.
REQ-017 pc  out  XLEN  architectural PC.
REQ-018 alu_op  out  6  funct for R-type, opcode otherwise.
REQ-019 alu_src_imm  out  1  1 = sign-extended immediate as ALU operand B.
REQ-020 reg_we  out  1  register-file write strobe.
REQ-021 dst_sel  out  2  write destination: 0 = rd, 1 = rt, 2 = r31.
REQ-022 wb_sel  out  2  write-back source: 0 = ALU, 1 = memory, 2 = pc+4.
REQ-023 retired  out  1  one-cycle pulse when an instruction completes.
REQ-024 illegal  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
REQ-025 instret  out  CNT_W  count of retired instructions.

Function
REQ-026 SHALL implement states FETCH, DECODE, EXEC, MEM, WB; state leaves reset as FETCH.
REQ-027 FETCH: imem_req=1 with imem_addr stable until imem_ready=1; on that edge, ir<=imem_rdata and state->DECODE.
REQ-028 imem_ready and dmem_ready SHALL be ignored while the matching req is low; a request SHALL wait indefinitely, with no timeout.
REQ-029 Supported opcodes: R=0, J=2, JAL=3, BEQ=4, BNE=5, ADDI=8, SLTI=10, ANDI=12, ORI=13, LW=35, SW=43.
REQ-030 DECODE, J: pc<=jump target; retire; ->FETCH.
REQ-031 DECODE, JAL: reg_we=1, dst_sel=2, wb_sel=2, pc<=jump target; retire; ->FETCH.
REQ-032 DECODE, R-type with funct 8 (jr): pc<=rs_data; retire; ->FETCH.
REQ-033 DECODE, illegal opcode: illegal=1, pc<=pc+4; retire as nop; ->FETCH.
REQ-034 DECODE, all other supported opcodes: ->EXEC.
REQ-035 EXEC: alu_op and alu_src_imm are driven (alu_src_imm=0 for R-type, BEQ and BNE; 1 otherwise).
REQ-036 EXEC, BEQ: taken iff alu_zero=1; BNE: taken iff alu_zero=0.
REQ-037 EXEC, branch: pc<=taken ? pc+4+(sext(imm)<<2) : pc+4; retire; ->FETCH.
REQ-038 EXEC, LW/SW: ->MEM; all other opcodes: ->WB.
REQ-039 MEM: dmem_req=1 with dmem_we=(SW), held until dmem_ready.
REQ-040 MEM, SW on dmem_ready: pc<=pc+4; retire; ->FETCH.
REQ-041 MEM, LW on dmem_ready: ->WB with wb_sel=1.
REQ-042 WB: reg_we=1 for exactly one cycle; dst_sel=0 for R-type, 1 otherwise; pc<=pc+4; retire; ->FETCH.
REQ-043 reg_we SHALL be suppressed when the selected destination register index is 0.
REQ-044 Jump target = {(pc+4)[XLEN-1:28], ir[25:0], 2'b00}; all PC arithmetic is modulo 2^XLEN, wrapping silently.
REQ-045 pc SHALL change only on a retire edge.
REQ-046 instret SHALL increment on every retire and wrap from all-ones to 0.
REQ-047 Outputs SHALL be decoded from the registered state and ir only; this block has no combinational paths from ready inputs to outputs.

Reset
REQ-048 On rst: state=FETCH, pc=RESET_PC, ir=0, instret=0; reg_we, retired, illegal, imem_req and dmem_req are low while rst is high.
REQ-049 rst asserted mid-access SHALL abort the transaction; the first fetch after release uses RESET_PC.

Structure
REQ-050 Opcode/funct constants, the state enum and the dst_sel/wb_sel encodings SHALL live in shared package mips_pkg.
REQ-051 PC next-value logic SHALL be one sub-module, mips_pc_next, covering +4, branch, jump and jr.

Verification
REQ-052 Scenario 1: reset, then imem_ready delayed 3 cycles with rdata=ADDI r1,r0,5 -> imem_req held 4 cycles; WB reg_we pulse with dst_sel=1; pc=4; instret=1.
REQ-053 Scenario 2: BEQ imm=-1 at pc=0x10 with alu_zero=1 -> pc=0x10; with alu_zero=0 -> pc=0x14.
REQ-054 Scenario 3: JAL target 0x40 at pc=0x8 -> reg_we with dst_sel=2 and wb_sel=2; pc=0x100.
REQ-055 Scenario 4: SW then LW with dmem_ready delayed 2 cycles -> dmem_we=1 then 0; LW gets a WB pulse with wb_sel=1; SW gets no reg_we.
REQ-056 Scenario 5: opcode 63 -> illegal pulse; pc+=4; instret+=1; rst asserted during MEM -> state=FETCH, pc=RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, FSM state and mux encodings for the
// multi-cycle MIPS controller.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_ANDI = 6'd12;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] FN_JR   = 6'd8;

  localparam logic [1:0] DST_RD = 2'd0;
  localparam logic [1:0] DST_RT = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4,
    PC_BRANCH,
    PC_JUMP,
    PC_JR
  } pc_sel_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
      OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW: op_supported = 1'b1;
      default:                               op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_pc_next.sv
// Next-PC selection: sequential, branch, jump and register-indirect targets.
module mips_pc_next
  import mips_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [25:0]     ir_low,
  input  logic [XLEN-1:0] rs_data,
  input  pc_sel_t         sel,
  output logic [XLEN-1:0] pc_next
);

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] jmp_tgt;

  assign pc4     = pc + XLEN'(4);
  assign br_off  = {{(XLEN-18){ir_low[15]}}, ir_low[15:0], 2'b00};
  assign jmp_tgt = {pc4[XLEN-1:28], ir_low, 2'b00};

  always_comb begin
    pc_next = pc4;
    case (sel)
      PC_PLUS4:  pc_next = pc4;
      PC_BRANCH: pc_next = pc4 + br_off;
      PC_JUMP:   pc_next = jmp_tgt;
      PC_JR:     pc_next = rs_data;
      default:   pc_next = pc4;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/wb sequencing, PC and
// instruction register, retire pulse and retired-instruction counter.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic [XLEN-1:0]  rs_data,
  input  logic             alu_zero,
  output logic [31:0]      ir,
  output logic [XLEN-1:0]  pc,
  output logic [5:0]       alu_op,
  output logic             alu_src_imm,
  output logic             reg_we,
  output logic [1:0]       dst_sel,
  output logic [1:0]       wb_sel,
  output logic             retired,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t          state, state_nxt;
  pc_sel_t         pc_sel;
  logic            retire_now;
  logic [XLEN-1:0] pc_nxt;
  logic [5:0]      opcode, funct;
  logic            is_rtype, is_jr, is_branch, br_taken;

  assign opcode    = ir[31:26];
  assign funct     = ir[5:0];
  assign is_rtype  = (opcode == OP_R);
  assign is_jr     = is_rtype && (funct == FN_JR);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign br_taken  = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;

  mips_pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc      (pc),
    .ir_low  (ir[25:0]),
    .rs_data (rs_data),
    .sel     (pc_sel),
    .pc_next (pc_nxt)
  );

  // Ready inputs only steer next-state/retire; outputs never see them.
  always_comb begin
    state_nxt  = state;
    retire_now = 1'b0;
    pc_sel     = PC_PLUS4;
    case (state)
      ST_FETCH: if (imem_ready) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (opcode == OP_J || opcode == OP_JAL) begin
          retire_now = 1'b1;
          pc_sel     = PC_JUMP;
          state_nxt  = ST_FETCH;
        end else if (is_jr) begin
          retire_now = 1'b1;
          pc_sel     = PC_JR;
          state_nxt  = ST_FETCH;
        end else if (!op_supported(opcode)) begin
          retire_now = 1'b1;
          state_nxt  = ST_FETCH;
        end else begin
          state_nxt  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_branch) begin
          retire_now = 1'b1;
          pc_sel     = br_taken ? PC_BRANCH : PC_PLUS4;
          state_nxt  = ST_FETCH;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_nxt  = ST_MEM;
        end else begin
          state_nxt  = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ready) begin
          if (opcode == OP_SW) begin
            retire_now = 1'b1;
            state_nxt  = ST_FETCH;
          end else begin
            state_nxt  = ST_WB;
          end
        end
      end
      ST_WB: begin
        retire_now = 1'b1;
        state_nxt  = ST_FETCH;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      instret <= '0;
      retired <= 1'b0;
    end else begin
      state   <= state_nxt;
      retired <= retire_now;
      if (state == ST_FETCH && imem_ready) ir <= imem_rdata;
      if (retire_now) begin
        pc      <= pc_nxt;
        instret <= instret + CNT_W'(1);
      end
    end
  end

  always_comb begin
    imem_req    = (state == ST_FETCH) && !rst;
    imem_addr   = pc;
    dmem_req    = (state == ST_MEM);
    dmem_we     = (state == ST_MEM) && (opcode == OP_SW);
    alu_op      = is_rtype ? funct : opcode;
    alu_src_imm = !(is_rtype || is_branch);
    illegal     = (state == ST_DECODE) && !op_supported(opcode);
    reg_we      = 1'b0;
    dst_sel     = DST_RD;
    wb_sel      = WB_ALU;
    if (state == ST_DECODE && opcode == OP_JAL) begin
      reg_we  = 1'b1;
      dst_sel = DST_RA;
      wb_sel  = WB_PC4;
    end else if (state == ST_WB) begin
      dst_sel = is_rtype ? DST_RD : DST_RT;
      wb_sel  = (opcode == OP_LW) ? WB_MEM : WB_ALU;
      reg_we  = is_rtype ? (ir[15:11] != 5'd0) : (ir[20:16] != 5'd0);
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized and directed bench for mips_mc_ctrl against an instruction-level
// reference model of PC, write-back and memory behaviour.
module tb_mips_mc_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ready = 1'b0;
  logic [31:0]      imem_rdata = '0;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ready = 1'b0;
  logic [31:0]      rs_data = '0;
  logic             alu_zero = 1'b0;
  logic [31:0]      ir;
  logic [31:0]      pc;
  logic [5:0]       alu_op;
  logic             alu_src_imm;
  logic             reg_we;
  logic [1:0]       dst_sel;
  logic [1:0]       wb_sel;
  logic             retired;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  int               n_checks = 0;
  int               n_pass   = 0;
  logic [31:0]      model_pc = '0;
  logic [CNT_W-1:0] model_instret = '0;

  mips_mc_ctrl #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rs_data(rs_data), .alu_zero(alu_zero),
    .ir(ir), .pc(pc), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .reg_we(reg_we), .dst_sel(dst_sel), .wb_sel(wb_sel),
    .retired(retired), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  // Instruction-level semantics: what one instruction does to the machine.
  task automatic ref_model(input logic [31:0] instr, input logic [31:0] cur_pc,
                           input logic az, input logic [31:0] rs,
                           output logic [31:0] npc, output int we,
                           output logic [1:0] dst, output logic [1:0] wb,
                           output int ill, output int mem, output logic st);
    int op, fn, rt, rd, simm;
    logic [31:0] pc4;
    op = int'(instr[31:26]); fn = int'(instr[5:0]);
    rt = int'(instr[20:16]); rd = int'(instr[15:11]);
    simm = int'($signed(instr[15:0]));
    pc4 = cur_pc + 32'd4;
    npc = pc4; we = 0; dst = 2'd0; wb = 2'd0; ill = 0; mem = 0; st = 1'b0;
    case (op)
      0: if (fn == 8) npc = rs;
         else begin we = (rd != 0) ? 1 : 0; dst = 2'd0; end
      2, 3: begin
        npc = (pc4 & 32'hF000_0000) | (32'(instr[25:0]) << 2);
        if (op == 3) begin we = 1; dst = 2'd2; wb = 2'd2; end
      end
      4, 5: if ((op == 4) == az) npc = pc4 + 32'(simm * 4);
      8, 10, 12, 13: begin we = (rt != 0) ? 1 : 0; dst = 2'd1; end
      35: begin mem = 1; we = (rt != 0) ? 1 : 0; dst = 2'd1; wb = 2'd1; end
      43: begin mem = 1; st = 1'b1; end
      default: ill = 1;
    endcase
  endtask

  // Serves one instruction (fetch latency idly, data latency ddly) and
  // compares the observed behaviour against ref_model.
  task automatic run_instr(input logic [31:0] instr, input int idly, input int ddly,
                           input logic az, input logic [31:0] rs);
    logic [31:0] exp_pc;
    int          exp_we, exp_ill, exp_mem;
    logic [1:0]  exp_dst, exp_wb;
    logic        exp_st, got_st, addr_ok, done;
    logic [1:0]  got_dst, got_wb;
    logic [5:0]  exp_aluop;
    int          ireq, dreq, we_cnt, ill_cnt, cyc;
    ref_model(instr, model_pc, az, rs, exp_pc, exp_we, exp_dst, exp_wb, exp_ill, exp_mem, exp_st);
    exp_aluop = (instr[31:26] == 6'd0) ? instr[5:0] : instr[31:26];
    ireq = 0; dreq = 0; we_cnt = 0; ill_cnt = 0; cyc = 0;
    got_st = 1'b0; got_dst = 2'd3; got_wb = 2'd3; addr_ok = 1'b1; done = 1'b0;
    alu_zero = az; rs_data = rs;
    while (!done && cyc < 100) begin
      if (cyc > 0 && retired) done = 1'b1;
      else begin
        if (imem_req) begin
          ireq++;
          if (imem_addr !== model_pc) addr_ok = 1'b0;
          imem_rdata = instr;
          imem_ready = (ireq > idly);
        end else imem_ready = 1'b0;
        if (dmem_req) begin
          dreq++;
          got_st = dmem_we;
          dmem_ready = (dreq > ddly);
        end else dmem_ready = 1'b0;
        if (reg_we) begin we_cnt++; got_dst = dst_sel; got_wb = wb_sel; end
        if (illegal) ill_cnt++;
        @(negedge clk);
        cyc++;
      end
    end
    n_checks++;
    if (!done) begin
      $display("FAIL retire_timeout instr=%h: no retire within 100 cycles", instr);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end else n_pass++;
    model_pc = exp_pc;
    model_instret = model_instret + 1'b1;
    n_checks++;
    if (pc !== exp_pc) $display("FAIL pc instr=%h: got %h expected %h", instr, pc, exp_pc);
    else n_pass++;
    n_checks++;
    if (instret !== model_instret)
      $display("FAIL instret instr=%h: got %0d expected %0d", instr, instret, model_instret);
    else n_pass++;
    n_checks++;
    if (ir !== instr) $display("FAIL ir: got %h expected %h", ir, instr);
    else n_pass++;
    n_checks++;
    if (ireq != idly + 1 || !addr_ok)
      $display("FAIL imem_req instr=%h: %0d req cycles (addr_ok=%0b) expected %0d", instr, ireq, addr_ok, idly + 1);
    else n_pass++;
    n_checks++;
    if (we_cnt != exp_we) $display("FAIL reg_we_count instr=%h: got %0d expected %0d", instr, we_cnt, exp_we);
    else n_pass++;
    if (exp_we > 0) begin
      n_checks++;
      if (got_dst !== exp_dst || got_wb !== exp_wb)
        $display("FAIL wb_mux instr=%h: dst/wb got %0d/%0d expected %0d/%0d", instr, got_dst, got_wb, exp_dst, exp_wb);
      else n_pass++;
    end
    n_checks++;
    if (ill_cnt != exp_ill) $display("FAIL illegal instr=%h: got %0d pulses expected %0d", instr, ill_cnt, exp_ill);
    else n_pass++;
    n_checks++;
    if (dreq != (exp_mem != 0 ? ddly + 1 : 0) || (exp_mem != 0 && got_st !== exp_st))
      $display("FAIL dmem instr=%h: req cycles %0d we %0b expected %0d we %0b", instr, dreq, got_st,
               exp_mem != 0 ? ddly + 1 : 0, exp_st);
    else n_pass++;
    n_checks++;
    if (alu_op !== exp_aluop || alu_src_imm !== !(instr[31:26] inside {6'd0, 6'd4, 6'd5}))
      $display("FAIL alu_ctrl instr=%h: op %0d imm %0b expected op %0d", instr, alu_op, alu_src_imm, exp_aluop);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({imem_req, dmem_req, reg_we, retired, illegal} !== 5'b0)
      $display("FAIL reset_strobes: got %b expected 00000", {imem_req, dmem_req, reg_we, retired, illegal});
    else n_pass++;
    n_checks++;
    if (pc !== 32'h0 || ir !== 32'h0 || instret !== '0)
      $display("FAIL reset_regs: pc %h ir %h instret %0d expected all 0", pc, ir, instret);
    else n_pass++;
    rst = 1'b0;
    model_pc = '0; model_instret = '0;
  endtask

  task automatic test_addi();
    run_instr({6'd8, 5'd0, 5'd1, 16'd5}, 3, 0, 1'b0, 32'h0);
  endtask

  task automatic test_branch();
    run_instr({6'd2, 26'd4}, 0, 0, 1'b0, 32'h0);
    run_instr({6'd4, 5'd1, 5'd2, 16'hFFFF}, 1, 0, 1'b1, 32'h0);
    run_instr({6'd4, 5'd1, 5'd2, 16'hFFFF}, 0, 0, 1'b0, 32'h0);
    run_instr({6'd5, 5'd1, 5'd2, 16'd3}, 0, 0, 1'b0, 32'h0);
    run_instr({6'd5, 5'd1, 5'd2, 16'd3}, 2, 0, 1'b1, 32'h0);
  endtask

  task automatic test_jal();
    run_instr({6'd2, 26'd2}, 0, 0, 1'b0, 32'h0);
    run_instr({6'd3, 26'h40}, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_mem();
    run_instr({6'd43, 5'd2, 5'd5, 16'h0010}, 0, 2, 1'b0, 32'h0);
    run_instr({6'd35, 5'd2, 5'd6, 16'h0010}, 0, 2, 1'b0, 32'h0);
    run_instr({6'd35, 5'd2, 5'd0, 16'h0004}, 1, 0, 1'b0, 32'h0);
    run_instr({6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'd32}, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_illegal_jr_wrap();
    run_instr({6'd63, 26'h3FF_FFFF}, 0, 0, 1'b0, 32'h0);
    run_instr({6'd0, 5'd3, 15'd0, 6'd8}, 0, 0, 1'b0, 32'hFFFF_FFFC);
    run_instr({6'd13, 5'd0, 5'd2, 16'h00FF}, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid_mem();
    imem_rdata = {6'd43, 5'd2, 5'd5, 16'h0020};
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1)
      $display("FAIL mid_mem_req: req %b we %b expected 1 1", dmem_req, dmem_we);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0 || instret !== '0)
      $display("FAIL mid_mem_abort: dreq %b ireq %b pc %h instret %0d expected 0 0 0 0",
               dmem_req, imem_req, pc, instret);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL refetch: req %b addr %h expected 1 00000000", imem_req, imem_addr);
    else n_pass++;
    model_pc = '0; model_instret = '0;
    run_instr({6'd12, 5'd1, 5'd4, 16'h0F0F}, 1, 0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    logic [5:0]  ops [14] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd10,
                              6'd12, 6'd13, 6'd35, 6'd43, 6'd63, 6'd1, 6'd17};
    logic [5:0]  fns [4]  = '{6'd8, 6'd32, 6'd36, 6'd42};
    logic [31:0] r, instr;
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      instr = {ops[$urandom_range(13, 0)], r[25:0]};
      if (instr[31:26] == 6'd0) instr[5:0] = fns[$urandom_range(3, 0)];
      run_instr(instr, $urandom_range(3, 0), $urandom_range(3, 0),
                1'($urandom_range(1, 0)), $urandom & 32'hFFFF_FFFC);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_jal();
    test_mem();
    test_illegal_jr_wrap();
    test_reset_mid_mem();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
